uart_instr_loader: RTL and testbench

Parametrised UART boot loader. It receives serial bytes on the CPU's RX pin and packs them into instruction words of 1–4 bytes. Each complete word is written to consecutive instruction-memory addresses. It sits between the board RX pin and the instruction RAM of TOP_CPU, and its completion/max-address outputs drive the CPU start logic. Over the single-byte loader it adds configurable word width, address depth, optional parity, framing/overflow reporting and idle-timeout end-of-load.

---
 rtl/uart_instr_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_instr_loader.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_instr_loader.sv
// UART boot loader: receives 8-bit frames on i_rx, packs them little-endian
// into BYTES_PER_WORD-byte words and writes each word to consecutive
// instruction-memory addresses. An idle line after at least one word ends the load.
//
// RX FSM    | meaning
// RX_IDLE   | line idle, waiting for a low sample
// RX_START  | half a bit in, confirming the start bit
// RX_DATA   | sampling 8 data bits at mid-bit, LSB first
// RX_PARITY | sampling the even-parity bit (PARITY_EN only)
// RX_STOP   | sampling the stop bit, then report the byte
//
// LD FSM    | meaning
// LD_WAIT   | disarmed, bytes ignored
// LD_LOAD   | assembling and writing words
// LD_DONE   | idle timeout reached, outputs frozen
module uart_instr_loader #(
  parameter int CLK_FREQ          = 100000000,
  parameter int BAUD              = 115200,
  parameter int BYTES_PER_WORD    = 1,
  parameter int ADDR_WIDTH        = 8,
  parameter int PARITY_EN         = 0,
  parameter int IDLE_TIMEOUT_BITS = 20
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_rx,
  input  logic                        i_enable,
  output logic                        o_wr_en,
  output logic [ADDR_WIDTH-1:0]       o_wr_addr,
  output logic [8*BYTES_PER_WORD-1:0] o_wr_data,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [ADDR_WIDTH-1:0]       o_max_addr,
  output logic [ADDR_WIDTH:0]         o_word_count,
  output logic                        o_frame_err,
  output logic                        o_partial,
  output logic                        o_overflow
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TIMEOUT_CLKS = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int BT_W         = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_W         = $clog2(TIMEOUT_CLKS + 1);
  localparam int DATA_W       = 8 * BYTES_PER_WORD;
  localparam int IDX_W        = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {LD_WAIT, LD_LOAD, LD_DONE} ld_state_t;

  rx_state_t             r_rx_state, w_rx_next;
  ld_state_t             r_ld_state, w_ld_next;
  logic                  r_rx_meta, r_rx_sync;
  logic [BT_W-1:0]       r_bit_timer;
  logic [2:0]            r_bit_idx;
  logic [7:0]            r_shift;
  logic                  r_par_bad;
  logic                  r_byte_valid, r_byte_bad;
  logic [7:0]            r_byte_data;
  logic [TO_W-1:0]       r_idle_timer;
  logic [IDX_W-1:0]      r_byte_idx;
  logic [DATA_W-1:0]     r_word, w_word_next;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  w_tick, w_timeout, w_full;

  assign w_tick    = (r_bit_timer == '0);
  assign w_timeout = (r_rx_state == RX_IDLE) && (r_idle_timer == '0);
  assign w_full    = o_word_count[ADDR_WIDTH];
  assign o_busy    = (r_ld_state == LD_LOAD);
  assign o_done    = (r_ld_state == LD_DONE);

  // Two-flop synchroniser for the asynchronous line, idles high
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // State registers for both FSMs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_state <= RX_IDLE;
      r_ld_state <= LD_WAIT;
    end else begin
      r_rx_state <= w_rx_next;
      r_ld_state <= w_ld_next;
    end
  end

  // RX next state: bit timer terminal count paces every transition after IDLE
  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:   if (!r_rx_sync) w_rx_next = RX_START;
      RX_START:  if (w_tick) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_tick && (r_bit_idx == 3'd7))
                   w_rx_next = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_tick) w_rx_next = RX_STOP;
      RX_STOP:   if (w_tick) w_rx_next = RX_IDLE;
      default:   w_rx_next = RX_IDLE;
    endcase
  end

  // Loader next state: disarm wins, timeout only ends a load that wrote something
  always_comb begin
    w_ld_next = r_ld_state;
    case (r_ld_state)
      LD_WAIT: if (i_enable) w_ld_next = LD_LOAD;
      LD_LOAD: begin
        if (!i_enable) w_ld_next = LD_WAIT;
        else if (w_timeout && (o_word_count != '0)) w_ld_next = LD_DONE;
      end
      LD_DONE: if (!i_enable) w_ld_next = LD_WAIT;
      default: w_ld_next = LD_WAIT;
    endcase
  end

  // RX datapath: down-counting bit timer, shift register and byte reporting
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_timer  <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_par_bad    <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte_bad   <= 1'b0;
      r_byte_data  <= '0;
    end else begin
      r_byte_valid <= 1'b0;
      r_byte_bad   <= 1'b0;
      if (r_rx_state == RX_IDLE) begin
        r_bit_timer <= BT_W'(HALF_BIT - 1);
        r_bit_idx   <= '0;
        r_par_bad   <= 1'b0;
      end else if (!w_tick) begin
        r_bit_timer <= r_bit_timer - 1'b1;
      end else begin
        r_bit_timer <= BT_W'(CLKS_PER_BIT - 1);
        case (r_rx_state)
          RX_DATA: begin
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
          end
          RX_PARITY: r_par_bad <= (r_rx_sync != ^r_shift);
          RX_STOP: begin
            if (r_rx_sync && !r_par_bad) begin
              r_byte_valid <= 1'b1;
              r_byte_data  <= r_shift;
            end else begin
              r_byte_bad <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Idle timer: reloads while a frame is in flight, counts down to zero when idle
  always_ff @(posedge i_clk) begin
    if (i_rst) r_idle_timer <= '0;
    else if (r_rx_state != RX_IDLE) r_idle_timer <= TO_W'(TIMEOUT_CLKS);
    else if (r_idle_timer != '0) r_idle_timer <= r_idle_timer - 1'b1;
  end

  // Current word with the incoming byte dropped into its lane
  always_comb begin
    w_word_next = r_word;
    w_word_next[8*r_byte_idx +: 8] = r_byte_data;
  end

  // Loader datapath: lane assembly, memory writes and sticky status
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_max_addr   <= '0;
      o_word_count <= '0;
      o_frame_err  <= 1'b0;
      o_partial    <= 1'b0;
      o_overflow   <= 1'b0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_ptr        <= '0;
    end else begin
      o_wr_en <= 1'b0;
      case (r_ld_state)
        LD_WAIT: if (i_enable) begin
          r_ptr        <= '0;
          r_byte_idx   <= '0;
          r_word       <= '0;
          o_word_count <= '0;
          o_frame_err  <= 1'b0;
          o_partial    <= 1'b0;
          o_overflow   <= 1'b0;
        end
        LD_LOAD: if (i_enable) begin
          if (r_byte_bad) o_frame_err <= 1'b1;
          if (r_byte_valid) begin
            if (r_byte_idx == LAST_IDX) begin
              r_byte_idx <= '0;
              if (w_full) begin
                o_overflow <= 1'b1;
              end else begin
                o_wr_en      <= 1'b1;
                o_wr_addr    <= r_ptr;
                o_wr_data    <= w_word_next;
                o_max_addr   <= r_ptr;
                o_word_count <= o_word_count + 1'b1;
                if (r_ptr != '1) r_ptr <= r_ptr + 1'b1;
              end
            end else begin
              r_word     <= w_word_next;
              r_byte_idx <= r_byte_idx + 1'b1;
            end
          end else if (w_timeout && (o_word_count != '0) && (r_byte_idx != '0)) begin
            o_partial  <= 1'b1;
            r_byte_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_instr_loader.sv
// Bench for uart_instr_loader: instance A (1-byte words, 4-entry memory, no
// parity) and instance B (2-byte words, 16-entry memory, even parity).
module tb_uart_instr_loader;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 31_250;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int TO_BITS  = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rx_a, en_a, wr_en_a, busy_a, done_a, ferr_a, part_a, ovf_a;
  logic [1:0]  addr_a, max_a;
  logic [7:0]  data_a;
  logic [2:0]  cnt_a;
  logic        rx_b, en_b, wr_en_b, busy_b, done_b, ferr_b, part_b, ovf_b;
  logic [3:0]  addr_b, max_b;
  logic [15:0] data_b;
  logic [4:0]  cnt_b;

  uart_instr_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .BYTES_PER_WORD(1),
    .ADDR_WIDTH(2), .PARITY_EN(0), .IDLE_TIMEOUT_BITS(TO_BITS)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_a), .i_enable(en_a), .o_wr_en(wr_en_a),
    .o_wr_addr(addr_a), .o_wr_data(data_a), .o_busy(busy_a), .o_done(done_a),
    .o_max_addr(max_a), .o_word_count(cnt_a), .o_frame_err(ferr_a),
    .o_partial(part_a), .o_overflow(ovf_a));

  uart_instr_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .BYTES_PER_WORD(2),
    .ADDR_WIDTH(4), .PARITY_EN(1), .IDLE_TIMEOUT_BITS(TO_BITS)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_rx(rx_b), .i_enable(en_b), .o_wr_en(wr_en_b),
    .o_wr_addr(addr_b), .o_wr_data(data_b), .o_busy(busy_b), .o_done(done_b),
    .o_max_addr(max_b), .o_word_count(cnt_b), .o_frame_err(ferr_b),
    .o_partial(part_b), .o_overflow(ovf_b));

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_a[$];
  wr_t exp_b[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // Scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    wr_t e;
    if (wr_en_a) begin
      n_tests++;
      if (exp_a.size() == 0) begin
        n_fail++;
        $display("FAIL wr_a: unexpected write addr=%0d data=%h, expected none", addr_a, data_a);
      end else begin
        e = exp_a.pop_front();
        if ({addr_a, data_a} !== {e.addr[1:0], e.data[7:0]}) begin
          n_fail++;
          $display("FAIL wr_a: got addr=%0d data=%h, expected addr=%0d data=%h",
                   addr_a, data_a, e.addr, e.data[7:0]);
        end
      end
    end
    if (wr_en_b) begin
      n_tests++;
      if (exp_b.size() == 0) begin
        n_fail++;
        $display("FAIL wr_b: unexpected write addr=%0d data=%h, expected none", addr_b, data_b);
      end else begin
        e = exp_b.pop_front();
        if ({addr_b, data_b} !== {e.addr[3:0], e.data}) begin
          n_fail++;
          $display("FAIL wr_b: got addr=%0d data=%h, expected addr=%0d data=%h",
                   addr_b, data_b, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit which, input logic v);
    if (which) rx_b = v;
    else       rx_a = v;
  endtask

  task automatic push(input bit which, input logic [7:0] addr, input logic [15:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    if (which) exp_b.push_back(e);
    else       exp_a.push_back(e);
  endtask

  // One frame plus two idle bit periods; B frames carry an even-parity bit
  task automatic send_byte(input bit which, input logic [7:0] b, input bit stop_ok, input bit par_ok);
    drive(which, 1'b0);
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      drive(which, b[i]);
      hold(CPB);
    end
    if (which) begin
      drive(which, (^b) ^ !par_ok);
      hold(CPB);
    end
    if (stop_ok) begin
      drive(which, 1'b1);
      hold(CPB);
    end else begin
      drive(which, 1'b0);
      hold(24);
      drive(which, 1'b1);
      hold(CPB - 24);
    end
    hold(2 * CPB);
  endtask

  task automatic wait_done(input bit which, input string name);
    int k = 0;
    while (!(which ? done_b : done_a) && k < 1500) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if ((which ? done_b : done_a) !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: o_done still %b after %0d cycles, expected 1", name, which ? done_b : done_a, k);
    end
  endtask

  task automatic check_drained(input bit which, input string name);
    n_tests++;
    if ((which ? exp_b.size() : exp_a.size()) != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected writes never seen, expected 0",
               name, which ? exp_b.size() : exp_a.size());
    end
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if ({wr_en_a, addr_a, data_a, busy_a, done_a, max_a, cnt_a, ferr_a, part_a, ovf_a} !== '0) begin
      n_fail++;
      $display("FAIL %s_a: outputs=%h, expected 0", name,
               {wr_en_a, addr_a, data_a, busy_a, done_a, max_a, cnt_a, ferr_a, part_a, ovf_a});
    end
    n_tests++;
    if ({wr_en_b, addr_b, data_b, busy_b, done_b, max_b, cnt_b, ferr_b, part_b, ovf_b} !== '0) begin
      n_fail++;
      $display("FAIL %s_b: outputs=%h, expected 0", name,
               {wr_en_b, addr_b, data_b, busy_b, done_b, max_b, cnt_b, ferr_b, part_b, ovf_b});
    end
  endtask

  task automatic rearm_a();
    en_a = 1'b0;
    hold(2);
    en_a = 1'b1;
    hold(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    hold(3);
    check_zero("reset");
    rst = 1'b0;
    hold(2);
  endtask

  task automatic test_basic();
    en_a = 1'b1;
    hold(2);
    n_tests++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, expected 1", busy_a); end
    hold(800);
    n_tests++;
    if (done_a !== 1'b0) begin n_fail++; $display("FAIL basic_no_words_done: got %b, expected 0", done_a); end
    push(0, 8'd0, 16'h41); push(0, 8'd1, 16'h00); push(0, 8'd2, 16'h80);
    send_byte(0, 8'h41, 1, 1);
    send_byte(0, 8'h00, 1, 1);
    send_byte(0, 8'h80, 1, 1);
    wait_done(0, "basic_done");
    n_tests++;
    if ({max_a, cnt_a, busy_a, ferr_a, part_a, ovf_a} !== {2'd2, 3'd3, 4'b0000}) begin
      n_fail++;
      $display("FAIL basic_status: max=%0d cnt=%0d busy=%b flags=%b%b%b, expected max=2 cnt=3 busy=0 flags=000",
               max_a, cnt_a, busy_a, ferr_a, part_a, ovf_a);
    end
    check_drained(0, "basic_drain");
    send_byte(0, 8'h77, 1, 1);
    n_tests++;
    if ({done_a, cnt_a} !== {1'b1, 3'd3}) begin
      n_fail++;
      $display("FAIL done_ignores: done=%b cnt=%0d, expected done=1 cnt=3", done_a, cnt_a);
    end
  endtask

  task automatic test_frame_err();
    en_a = 1'b0;
    hold(2);
    n_tests++;
    if ({done_a, max_a, cnt_a} !== {1'b0, 2'd2, 3'd3}) begin
      n_fail++;
      $display("FAIL disable_hold: done=%b max=%0d cnt=%0d, expected done=0 max=2 cnt=3", done_a, max_a, cnt_a);
    end
    en_a = 1'b1;
    hold(2);
    n_tests++;
    if ({busy_a, cnt_a} !== {1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL arm_clear: busy=%b cnt=%0d, expected busy=1 cnt=0", busy_a, cnt_a);
    end
    send_byte(0, 8'h55, 0, 1);
    n_tests++;
    if ({ferr_a, cnt_a} !== {1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL frame_err: ferr=%b cnt=%0d, expected ferr=1 cnt=0", ferr_a, cnt_a);
    end
    push(0, 8'd0, 16'h26);
    send_byte(0, 8'h26, 1, 1);
    wait_done(0, "frame_done");
    n_tests++;
    if ({ferr_a, max_a, cnt_a} !== {1'b1, 2'd0, 3'd1}) begin
      n_fail++;
      $display("FAIL frame_status: ferr=%b max=%0d cnt=%0d, expected ferr=1 max=0 cnt=1", ferr_a, max_a, cnt_a);
    end
    check_drained(0, "frame_drain");
  endtask

  task automatic test_false_start();
    rearm_a();
    rx_a = 1'b0;
    hold(12);
    rx_a = 1'b1;
    hold(3 * CPB);
    n_tests++;
    if ({ferr_a, cnt_a} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL false_start: ferr=%b cnt=%0d, expected ferr=0 cnt=0", ferr_a, cnt_a);
    end
    push(0, 8'd0, 16'h5A);
    send_byte(0, 8'h5A, 1, 1);
    check_drained(0, "false_start_drain");
  endtask

  task automatic test_overflow();
    rearm_a();
    for (int i = 0; i < 4; i++) push(0, 8'(i), 16'(8'h11 * (i + 1)));
    for (int i = 0; i < 4; i++) send_byte(0, 8'(8'h11 * (i + 1)), 1, 1);
    n_tests++;
    if ({ovf_a, cnt_a} !== {1'b0, 3'd4}) begin
      n_fail++;
      $display("FAIL full_no_ovf: ovf=%b cnt=%0d, expected ovf=0 cnt=4", ovf_a, cnt_a);
    end
    send_byte(0, 8'h55, 1, 1);
    wait_done(0, "ovf_done");
    n_tests++;
    if ({ovf_a, max_a, cnt_a} !== {1'b1, 2'd3, 3'd4}) begin
      n_fail++;
      $display("FAIL overflow: ovf=%b max=%0d cnt=%0d, expected ovf=1 max=3 cnt=4", ovf_a, max_a, cnt_a);
    end
    check_drained(0, "ovf_drain");
  endtask

  task automatic test_word2();
    en_b = 1'b1;
    hold(2);
    push(1, 8'd0, 16'h0041);
    push(1, 8'd1, 16'hC080);
    send_byte(1, 8'h41, 1, 1);
    send_byte(1, 8'h00, 1, 1);
    send_byte(1, 8'h80, 1, 1);
    send_byte(1, 8'hC0, 1, 1);
    send_byte(1, 8'h21, 1, 1);
    n_tests++;
    if ({part_b, cnt_b} !== {1'b0, 5'd2}) begin
      n_fail++;
      $display("FAIL word2_mid: partial=%b cnt=%0d, expected partial=0 cnt=2", part_b, cnt_b);
    end
    wait_done(1, "word2_done");
    n_tests++;
    if ({part_b, max_b, cnt_b, ferr_b} !== {1'b1, 4'd1, 5'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL word2_status: partial=%b max=%0d cnt=%0d ferr=%b, expected partial=1 max=1 cnt=2 ferr=0",
               part_b, max_b, cnt_b, ferr_b);
    end
    check_drained(1, "word2_drain");
  endtask

  task automatic test_parity();
    en_b = 1'b0;
    hold(2);
    en_b = 1'b1;
    hold(2);
    send_byte(1, 8'h01, 1, 0);
    n_tests++;
    if ({ferr_b, cnt_b} !== {1'b1, 5'd0}) begin
      n_fail++;
      $display("FAIL parity_err: ferr=%b cnt=%0d, expected ferr=1 cnt=0", ferr_b, cnt_b);
    end
    push(1, 8'd0, 16'h0201);
    send_byte(1, 8'h01, 1, 1);
    send_byte(1, 8'h02, 1, 1);
    wait_done(1, "parity_done");
    n_tests++;
    if ({cnt_b, part_b, ferr_b} !== {5'd1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL parity_status: cnt=%0d partial=%b ferr=%b, expected cnt=1 partial=0 ferr=1",
               cnt_b, part_b, ferr_b);
    end
    check_drained(1, "parity_drain");
  endtask

  task automatic test_reset_mid();
    rearm_a();
    rx_a = 1'b0;
    hold(4 * CPB + CPB / 2);
    rst = 1'b1;
    hold(1);
    check_zero("reset_mid");
    en_a = 1'b0;
    hold(1);
    rst = 1'b0;
    hold(4);
    rx_a = 1'b1;
    hold(2 * CPB);
    en_a = 1'b1;
    hold(2);
    push(0, 8'd0, 16'hE0);
    send_byte(0, 8'hE0, 1, 1);
    check_drained(0, "reset_mid_drain");
    n_tests++;
    if ({cnt_a, max_a, ferr_a} !== {3'd1, 2'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_status: cnt=%0d max=%0d ferr=%b, expected cnt=1 max=0 ferr=0", cnt_a, max_a, ferr_a);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_false_start();
    test_overflow();
    test_word2();
    test_parity();
    test_reset_mid();
    hold(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
